// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared MEM/WB pipeline definitions: writeback control bundle, skid occupancy
// states and default datapath widths.
package mem_wb_skid_stage_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RA_W  = 4;

    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_stage_entry_reg.sv
// Enable-loaded register holding one complete MEM/WB entry; used for both the
// main (output) slot and the skid slot.
module mem_wb_entry_reg
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  wb_ctrl_t         next_ctrl,
    input  logic [WIDTH-1:0] next_read_data,
    input  logic [WIDTH-1:0] next_alu_out,
    input  logic [RA_W-1:0]  next_wa3,
    output wb_ctrl_t         held_ctrl,
    output logic [WIDTH-1:0] held_read_data,
    output logic [WIDTH-1:0] held_alu_out,
    output logic [RA_W-1:0]  held_wa3
);

    always_ff @(posedge clk) begin
        if (reset) begin
            held_ctrl      <= '0;
            held_read_data <= '0;
            held_alu_out   <= '0;
            held_wa3       <= '0;
        end else if (load) begin
            held_ctrl      <= next_ctrl;
            held_read_data <= next_read_data;
            held_alu_out   <= next_alu_out;
            held_wa3       <= next_wa3;
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, WB stall/flush, optional
// two-entry skid buffer and registered writeback result select.
module mem_wb_skid_stage
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidM,
    output logic             ReadyM,
    input  logic             FlushM,
    input  logic             StallW,
    input  logic             FlushW,
    input  logic             PCSrcM,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic [WIDTH-1:0] ReadDataM,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [RA_W-1:0]  WA3M,
    output logic             ValidW,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] ALUOutW,
    output logic [RA_W-1:0]  WA3W,
    output logic [WIDTH-1:0] ResultW
);

    skid_state_t      state;
    logic             accept;
    logic             consume;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;

    wb_ctrl_t         in_ctrl;
    wb_ctrl_t         main_ctrl;
    wb_ctrl_t         skid_ctrl;
    wb_ctrl_t         main_next_ctrl;
    logic [WIDTH-1:0] main_read_data;
    logic [WIDTH-1:0] main_alu_out;
    logic [WIDTH-1:0] skid_read_data;
    logic [WIDTH-1:0] skid_alu_out;
    logic [WIDTH-1:0] main_next_read_data;
    logic [WIDTH-1:0] main_next_alu_out;
    logic [RA_W-1:0]  main_wa3;
    logic [RA_W-1:0]  skid_wa3;
    logic [RA_W-1:0]  main_next_wa3;

    assign in_ctrl = {PCSrcM, RegWriteM, MemtoRegM};

    assign ValidW  = (state != EMPTY);
    assign accept  = ValidM & ReadyM & ~FlushM;
    assign consume = ValidW & ~StallW;

    // With a skid slot, ReadyM depends on occupancy only, so StallW never
    // reaches MEM combinationally.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign ReadyM = (state != TWO);
        end else begin : g_ready_flat
            assign ReadyM = ~ValidW | ~StallW;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else if (FlushW) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (consume && !accept) state <= EMPTY;
                    else if (!consume && accept) state <= TWO;
                end
                TWO: if (consume) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // A flush suppresses every load so held data fields keep their old values.
    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!FlushW) begin
            case (state)
                EMPTY: main_load = accept;
                ONE: begin
                    main_load = consume & accept;
                    skid_load = ~consume & accept;
                end
                TWO: begin
                    main_load      = consume;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign main_next_ctrl      = main_from_skid ? skid_ctrl      : in_ctrl;
    assign main_next_read_data = main_from_skid ? skid_read_data : ReadDataM;
    assign main_next_alu_out   = main_from_skid ? skid_alu_out   : ALUOutM;
    assign main_next_wa3       = main_from_skid ? skid_wa3       : WA3M;

    mem_wb_entry_reg #(
        .WIDTH(WIDTH),
        .RA_W (RA_W)
    ) u_main (
        .clk           (clk),
        .reset         (reset),
        .load          (main_load),
        .next_ctrl     (main_next_ctrl),
        .next_read_data(main_next_read_data),
        .next_alu_out  (main_next_alu_out),
        .next_wa3      (main_next_wa3),
        .held_ctrl     (main_ctrl),
        .held_read_data(main_read_data),
        .held_alu_out  (main_alu_out),
        .held_wa3      (main_wa3)
    );

    generate
        if (SKID != 0) begin : g_skid
            mem_wb_entry_reg #(
                .WIDTH(WIDTH),
                .RA_W (RA_W)
            ) u_skid (
                .clk           (clk),
                .reset         (reset),
                .load          (skid_load),
                .next_ctrl     (in_ctrl),
                .next_read_data(ReadDataM),
                .next_alu_out  (ALUOutM),
                .next_wa3      (WA3M),
                .held_ctrl     (skid_ctrl),
                .held_read_data(skid_read_data),
                .held_alu_out  (skid_alu_out),
                .held_wa3      (skid_wa3)
            );
        end else begin : g_no_skid
            assign skid_ctrl      = '0;
            assign skid_read_data = '0;
            assign skid_alu_out   = '0;
            assign skid_wa3       = '0;
        end
    endgenerate

    assign PCSrcW    = ValidW & main_ctrl.pc_src;
    assign RegWriteW = ValidW & main_ctrl.reg_write;
    assign MemtoRegW = main_ctrl.mem_to_reg;
    assign ReadDataW = main_read_data;
    assign ALUOutW   = main_alu_out;
    assign WA3W      = main_wa3;
    assign ResultW   = main_ctrl.mem_to_reg ? main_read_data : main_alu_out;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: SKID=1 and SKID=0 instances share stimulus and
// are each compared every cycle against a FIFO-occupancy reference model.
module tb_mem_wb_skid_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ValidM, FlushM, StallW, FlushW;
    logic        PCSrcM, RegWriteM, MemtoRegM;
    logic [31:0] ReadDataM, ALUOutM;
    logic [3:0]  WA3M;

    logic        ready1, valid1, pc1, rw1, m2r1;
    logic [31:0] rd1, alu1, res1;
    logic [3:0]  wa1;
    logic        ready0, valid0, pc0, rw0, m2r0;
    logic [31:0] rd0, alu0, res0;
    logic [3:0]  wa0;

    mem_wb_skid_stage #(.WIDTH(32), .RA_W(4), .SKID(1)) u_dut_skid (
        .clk(clk), .reset(reset), .ValidM(ValidM), .ReadyM(ready1), .FlushM(FlushM),
        .StallW(StallW), .FlushW(FlushW), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WA3M(WA3M),
        .ValidW(valid1), .PCSrcW(pc1), .RegWriteW(rw1), .MemtoRegW(m2r1),
        .ReadDataW(rd1), .ALUOutW(alu1), .WA3W(wa1), .ResultW(res1)
    );

    mem_wb_skid_stage #(.WIDTH(32), .RA_W(4), .SKID(0)) u_dut_flat (
        .clk(clk), .reset(reset), .ValidM(ValidM), .ReadyM(ready0), .FlushM(FlushM),
        .StallW(StallW), .FlushW(FlushW), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM), .WA3M(WA3M),
        .ValidW(valid0), .PCSrcW(pc0), .RegWriteW(rw0), .MemtoRegW(m2r0),
        .ReadDataW(rd0), .ALUOutW(alu0), .WA3W(wa0), .ResultW(res0)
    );

    typedef struct packed {
        logic        pc;
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [3:0]  wa;
    } ent_t;

    // Model: index 1 = SKID=1 (capacity 2), index 0 = SKID=0 (capacity 1).
    ent_t mq [2][2];
    int   cnt [2] = '{0, 0};
    ent_t held [2];
    bit   armed = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready(input int i);
        if (i == 1) return cnt[i] < 2;
        return (cnt[i] == 0) || !StallW;
    endfunction

    task automatic check_dut(input int i);
        logic        o_ready, o_valid, o_pc, o_rw, o_m2r;
        logic [31:0] o_rd, o_alu, o_res;
        logic [3:0]  o_wa;
        logic        v;
        ent_t        h;
        if (i == 1) begin
            o_ready = ready1; o_valid = valid1; o_pc = pc1; o_rw = rw1; o_m2r = m2r1;
            o_rd = rd1; o_alu = alu1; o_res = res1; o_wa = wa1;
        end else begin
            o_ready = ready0; o_valid = valid0; o_pc = pc0; o_rw = rw0; o_m2r = m2r0;
            o_rd = rd0; o_alu = alu0; o_res = res0; o_wa = wa0;
        end
        v = cnt[i] > 0;
        h = v ? mq[i][0] : held[i];
        check($sformatf("s%0d_ready", i), o_ready, exp_ready(i));
        check($sformatf("s%0d_valid", i), o_valid, v);
        check($sformatf("s%0d_pcsrc", i), o_pc, v & h.pc);
        check($sformatf("s%0d_regwrite", i), o_rw, v & h.rw);
        check($sformatf("s%0d_memtoreg", i), o_m2r, h.m2r);
        check($sformatf("s%0d_readdata", i), o_rd, h.rd);
        check($sformatf("s%0d_aluout", i), o_alu, h.alu);
        check($sformatf("s%0d_wa3", i), o_wa, h.wa);
        check($sformatf("s%0d_result", i), o_res, h.m2r ? h.rd : h.alu);
    endtask

    task automatic model_edge(input int i, input bit rdy);
        bit   cons, acc;
        ent_t e;
        e = {PCSrcM, RegWriteM, MemtoRegM, ReadDataM, ALUOutM, WA3M};
        if (reset) begin
            cnt[i]  = 0;
            held[i] = '0;
        end else if (FlushW) begin
            cnt[i] = 0;
        end else begin
            cons = (cnt[i] > 0) && !StallW;
            acc  = ValidM && rdy && !FlushM;
            if (cons) begin
                mq[i][0] = mq[i][1];
                cnt[i]--;
            end
            if (acc) begin
                mq[i][cnt[i]] = e;
                cnt[i]++;
            end
            if (cnt[i] > 0) held[i] = mq[i][0];
        end
    endtask

    task automatic step(input logic rst, input logic vm, input logic fm, input logic sw,
                        input logic fw, input logic pc, input logic rw, input logic m2r,
                        input logic [31:0] rd, input logic [31:0] alu, input logic [3:0] wa);
        bit r1, r0;
        reset = rst; ValidM = vm; FlushM = fm; StallW = sw; FlushW = fw;
        PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r;
        ReadDataM = rd; ALUOutM = alu; WA3M = wa;
        #1;
        if (armed) begin
            check_dut(1);
            check_dut(0);
        end
        r1 = exp_ready(1);
        r0 = exp_ready(0);
        @(posedge clk);
        model_edge(1, r1);
        model_edge(0, r0);
        if (rst) armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input logic sw);
        step(0, 0, 0, sw, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        check("rst_valid", valid1, 1'b0);
        check("rst_ready", ready1, 1'b1);
        check("rst_result", res1, 32'h0);

        // basic load-result and ALU-result paths
        step(0, 1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'h10, 4'd3);
        check("p1_valid", valid1, 1'b1);
        check("p1_regwrite", rw1, 1'b1);
        check("p1_wa3", wa1, 4'd3);
        check("p1_result_load", res1, 32'hDEADBEEF);
        step(0, 1, 0, 0, 0, 0, 1, 0, 32'hCAFE0000, 32'h10, 4'd3);
        check("p1_result_alu", res1, 32'h10);
        idle(0);

        // stalled back-to-back A, B, C
        step(0, 1, 0, 1, 0, 1, 1, 0, 32'h0, 32'hA1, 4'd1);
        check("p5_flat_ready_stalled", ready0, 1'b0);
        step(0, 1, 0, 1, 0, 0, 1, 0, 32'h0, 32'hA2, 4'd2);
        check("p2_ready_full", ready1, 1'b0);
        check("p2_main_is_a", alu1, 32'hA1);
        step(0, 1, 0, 1, 0, 0, 1, 0, 32'h0, 32'hA3, 4'd4);
        step(0, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'hA3, 4'd4);
        check("p2_out_b", alu1, 32'hA2);
        step(0, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'hA3, 4'd4);
        check("p2_out_c", alu1, 32'hA3);
        check("p2_ready_back", ready1, 1'b1);
        idle(0);

        // flush from full
        step(0, 1, 0, 1, 0, 1, 1, 0, 32'h0, 32'hB1, 4'd5);
        step(0, 1, 0, 1, 0, 1, 1, 0, 32'h0, 32'hB2, 4'd6);
        step(0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        check("p3_valid", valid1, 1'b0);
        check("p3_regwrite", rw1, 1'b0);
        check("p3_pcsrc", pc1, 1'b0);
        check("p3_ready", ready1, 1'b1);
        step(0, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'hB3, 4'd7);
        check("p3_new_entry", alu1, 32'hB3);
        idle(0);

        // FlushM alone and together with FlushW
        step(0, 1, 1, 0, 0, 1, 1, 0, 32'h0, 32'hC1, 4'd8);
        check("p4_valid", valid1, 1'b0);
        check("p4_pcsrc", pc1, 1'b0);
        step(0, 1, 1, 0, 1, 1, 1, 0, 32'h0, 32'hC2, 4'd9);
        check("p4_both_valid", valid1, 1'b0);

        // reset while full
        step(0, 1, 0, 1, 0, 1, 1, 1, 32'h55, 32'hD1, 4'd10);
        step(0, 1, 0, 1, 0, 1, 1, 1, 32'h66, 32'hD2, 4'd11);
        step(1, 1, 0, 1, 0, 1, 1, 1, 32'h77, 32'hD3, 4'd12);
        check("p6_valid", valid1, 1'b0);
        check("p6_ready", ready1, 1'b1);
        check("p6_readdata", rd1, 32'h0);
        check("p6_wa3", wa1, 4'h0);
        step(0, 1, 0, 0, 0, 0, 1, 0, 32'h88, 32'hD4, 4'd13);
        check("p6_after_reset", alu1, 32'hD4);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom, $urandom, 4'($urandom));
        end
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised MEM→WB pipeline register for the pipelined ARM core.
- Adds what a plain MEM/WB flop lacks:
  - valid/ready handshake with the memory stage
  - WB stall and flush
  - optional 2-entry skid buffer, so MEM can retire one more result while WB is stalled
  - registered writeback result mux (ResultW)
- Sits between the data-memory stage and the register-file write port and PC-writeback path.

Parameters:
- WIDTH, 32, data width of ReadData/ALUOut/Result.
- RA_W, 4, register-address width (WA3).
- SKID, 1, 1 = two-entry skid buffer; 0 = single register, no skid entry.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ValidM  in  1  MEM stage presents an entry.
- ReadyM  out  1  stage can accept an entry this cycle.
- FlushM  in  1  kill the incoming MEM entry (not accepted).
- StallW  in  1  WB cannot consume its entry this cycle.
- FlushW  in  1  discard all held entries.
- PCSrcM  in  1  writeback targets PC.
- RegWriteM  in  1  register write enable.
- MemtoRegM  in  1  result source select: 1 = ReadData, 0 = ALUOut.
- ReadDataM  in  WIDTH  load data.
- ALUOutM  in  WIDTH  ALU result.
- WA3M  in  RA_W  destination register.
- ValidW  out  1  output entry valid.
- PCSrcW  out  1  gated by ValidW.
- RegWriteW  out  1  gated by ValidW.
- MemtoRegW  out  1  held field.
- ReadDataW  out  WIDTH  held field.
- ALUOutW  out  WIDTH  held field.
- WA3W  out  RA_W  held field.
- ResultW  out  WIDTH  MemtoRegW ? ReadDataW : ALUOutW.

Behaviour:
- Single clock clk. Reset is synchronous, active-high, named reset.
- Definitions:
  - accept = ValidM & ReadyM & ~FlushM
  - consume = ValidW & ~StallW
- Latency: an entry accepted in cycle n appears on the W outputs in cycle n+1 if the main register is empty or consumed that cycle.
- Storage:
  - main register drives the W outputs
  - skid register is present only when SKID=1
- State machine (SKID=1):
  - EMPTY: accept → ONE (main ← input).
  - ONE:
    - consume & accept → ONE (main ← input)
    - consume & ~accept → EMPTY
    - ~consume & accept → TWO (skid ← input)
    - neither → ONE (hold)
  - TWO: ReadyM=0, so no accept.
    - consume → ONE (main ← skid)
    - ~consume → TWO (hold)
- ReadyM rules:
  - SKID=1: ReadyM = (state != TWO). Decoded from state only; no combinational path from StallW.
  - SKID=0: ReadyM = ~ValidW | ~StallW (combinational); TWO unreachable.
- Output gating:
  - ValidW = (state != EMPTY).
  - PCSrcW and RegWriteW are 0 whenever ValidW=0.
  - Data fields hold their last value when invalid.
- ResultW is computed combinationally from main-register fields. No extra latency.
- FlushW:
  - Next state is EMPTY; overrides accept and consume in the same cycle.
  - ReadyM=1 in the following cycle.
  - Data registers are not cleared.
- FlushM only suppresses accept; held entries are unaffected.
- FlushW and FlushM in the same cycle: state EMPTY, input dropped.
- Reset: state EMPTY; all data/control registers 0; ValidW=0, ReadyM=1.
- Reset asserted mid-operation (state TWO) → EMPTY next edge; pending entries lost.
- Ordering: entries leave in acceptance order. The skid entry is never output before the main entry.
- No X propagation: outputs are defined from the first edge after reset.

Decomposition:
- Shared package (core pipeline package):
  - typedef of the MEM/WB control bundle {PCSrc, RegWrite, MemtoReg}
  - skid state enum {EMPTY, ONE, TWO}
  - default WIDTH/RA_W constants
- One natural sub-module, mem_wb_entry_reg:
  - enable-loaded register of the full entry {ctrl, ReadData, ALUOut, WA3}
  - instantiated once for main, once for skid (generate on SKID)

Test Plan:
1. Reset, then ValidM=1, RegWriteM=1, MemtoRegM=1, ReadDataM=0xDEADBEEF, ALUOutM=0x10, WA3M=3, StallW=0 → next cycle ValidW=1, RegWriteW=1, WA3W=3, ResultW=0xDEADBEEF; with MemtoRegM=0 → ResultW=0x10.
2. StallW=1 held; three back-to-back entries A, B, C with SKID=1 → A in main, B in skid, ReadyM=0 on the cycle after B. C is held off. Release StallW → outputs A, B, C on consecutive cycles; ReadyM returns to 1.
3. State TWO plus FlushW=1 → next cycle ValidW=0, RegWriteW=0, PCSrcW=0, ReadyM=1. A new entry is accepted the cycle after.
4. ValidM=1, FlushM=1, PCSrcM=1 in EMPTY → ValidW stays 0 and PCSrcW stays 0. Same with FlushW=1 simultaneously → EMPTY.
5. SKID=0, StallW=1 with ValidW=1 → ReadyM=0 combinationally. StallW=0 with ValidM=1 → consume and accept in the same cycle; throughput is one entry per cycle.
6. Reset asserted while in TWO → next cycle all outputs 0, ReadyM=1. Entries accepted after reset are unaffected by pre-reset data.
